// File: rtl/xpb_reduce_sequencer.sv
// Walks NUM_SEG digit segments through one shared XPB table port and sums the results.
// Optional XPB_SKIP_ZERO_EN: visit only nonzero digits via a priority encoder.
module xpb_reduce_sequencer #(
    parameter int NUM_SEG  = 8,
    parameter int SEG_BITS = 5,
    parameter int XPB_BITS = 1024,
    parameter int ACC_BITS = 1028,
    localparam int SEL_W   = (NUM_SEG > 1) ? $clog2(NUM_SEG) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NUM_SEG*SEG_BITS-1:0] in_digits,
    input  logic [XPB_BITS-1:0]         in_base,
    output logic [SEL_W-1:0]            xpb_sel,
    output logic [SEG_BITS-1:0]         xpb_data,
    input  logic [XPB_BITS-1:0]         xpb_value,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACC_BITS-1:0]         out_sum,
    output logic                        busy
);

    typedef enum logic [1:0] {IDLE, LOOKUP, DONE} state_t;

    state_t                             state, state_nxt;
    logic [NUM_SEG-1:0][SEG_BITS-1:0]   digits_q;
    logic [ACC_BITS-1:0]                acc_q;
    logic [SEL_W-1:0]                   seg_q, seg_nxt;

`ifdef XPB_SKIP_ZERO_EN
    logic [NUM_SEG-1:0][SEG_BITS-1:0]   digits_in;
    logic                               first_hit, next_hit;
    logic [SEL_W-1:0]                   first_idx, next_idx;

    assign digits_in = in_digits;

    // Descending scan so the lowest qualifying index wins.
    always_comb begin
        first_hit = 1'b0;
        first_idx = '0;
        next_hit  = 1'b0;
        next_idx  = '0;
        for (int k = NUM_SEG - 1; k >= 0; k--) begin
            if (|digits_in[k]) begin
                first_hit = 1'b1;
                first_idx = SEL_W'(k);
            end
            if ((|digits_q[k]) && (SEL_W'(k) > seg_q)) begin
                next_hit = 1'b1;
                next_idx = SEL_W'(k);
            end
        end
    end
`endif

    always_comb begin
        state_nxt = state;
        seg_nxt   = seg_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        xpb_sel   = '0;
        xpb_data  = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
`ifdef XPB_SKIP_ZERO_EN
                    seg_nxt   = first_idx;
                    state_nxt = first_hit ? LOOKUP : DONE;
`else
                    seg_nxt   = '0;
                    state_nxt = LOOKUP;
`endif
                end
            end
            LOOKUP: begin
                busy     = 1'b1;
                xpb_sel  = seg_q;
                xpb_data = digits_q[seg_q];
`ifdef XPB_SKIP_ZERO_EN
                if (next_hit) seg_nxt = next_idx;
                else          state_nxt = DONE;
`else
                if (seg_q == SEL_W'(NUM_SEG - 1)) state_nxt = DONE;
                else                              seg_nxt = seg_q + 1'b1;
`endif
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            seg_q    <= '0;
            digits_q <= '0;
            acc_q    <= '0;
        end else begin
            state <= state_nxt;
            seg_q <= seg_nxt;
            if (state == IDLE && in_valid) begin
                digits_q <= in_digits;
                acc_q    <= {{(ACC_BITS-XPB_BITS){1'b0}}, in_base};
            end else if (state == LOOKUP) begin
                acc_q <= acc_q + {{(ACC_BITS-XPB_BITS){1'b0}}, xpb_value};
            end
        end
    end

    // Accumulator only moves in LOOKUP, so it is stable throughout DONE.
    assign out_sum = acc_q;

endmodule

// File: tb/tb_xpb_reduce_sequencer.sv
// Directed bench for xpb_reduce_sequencer; table model returns sel*16 + data.
module tb_xpb_reduce_sequencer;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [39:0]   in_digits = '0;
    logic [1023:0] in_base = '0;
    logic [2:0]    xpb_sel;
    logic [4:0]    xpb_data;
    logic [1023:0] xpb_value;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [1027:0] out_sum;
    logic          busy;
    logic          model_max = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    always_comb xpb_value = model_max ? {1024{1'b1}} : ((1024'(xpb_sel) << 4) + 1024'(xpb_data));

    xpb_reduce_sequencer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_digits(in_digits), .in_base(in_base), .xpb_sel(xpb_sel), .xpb_data(xpb_data),
        .xpb_value(xpb_value), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .busy(busy)
    );

    function automatic logic [39:0] all_dig(input logic [4:0] d);
        return {8{d}};
    endfunction

    // Handshake in the cycle ending at the next posedge; returns just after it.
    task automatic start(input logic [39:0] d, input logic [1023:0] b);
        in_digits = d;
        in_base   = b;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got %0h expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got %0h expected 0", out_valid); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %0h expected 0", busy); end
        checks++; if (out_sum !== 1028'd0) begin failures++; $display("FAIL reset_out_sum got %0h expected 0", out_sum); end
        checks++; if (xpb_sel !== 3'd0 || xpb_data !== 5'd0) begin failures++; $display("FAIL reset_xpb got sel=%0h data=%0h expected 0/0", xpb_sel, xpb_data); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fixed_latency();
        start(all_dig(5'd1), '0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++; if (xpb_sel !== 3'(k) || xpb_data !== 5'd1) begin failures++; $display("FAIL fixed_step%0d got sel=%0h data=%0h expected sel=%0h data=1", k, xpb_sel, xpb_data, k); end
            checks++; if (busy !== 1'b1 || out_valid !== 1'b0 || in_ready !== 1'b0) begin failures++; $display("FAIL fixed_flags%0d got busy=%0h ov=%0h ir=%0h expected 1/0/0", k, busy, out_valid, in_ready); end
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL fixed_out_valid got %0h expected 1", out_valid); end
        checks++; if (out_sum !== 1028'd456) begin failures++; $display("FAIL fixed_out_sum got %0h expected %0h", out_sum, 1028'd456); end
        checks++; if (xpb_sel !== 3'd0 || xpb_data !== 5'd0) begin failures++; $display("FAIL done_xpb got sel=%0h data=%0h expected 0/0", xpb_sel, xpb_data); end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL fixed_idle got ir=%0h ov=%0h busy=%0h expected 1/0/0", in_ready, out_valid, busy); end
    endtask

    task automatic test_acc_width();
        logic [1027:0] exp_sum;
        exp_sum = (1028'd1 << 1027) + (1028'd1 << 1024) - 1028'd9;
        @(posedge clk);
        #1 model_max = 1'b1;
        start(all_dig(5'd1), {1024{1'b1}});
        repeat (8) @(negedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL width_out_valid got %0h expected 1", out_valid); end
        checks++; if (out_sum !== exp_sum) begin failures++; $display("FAIL width_out_sum got %0h expected %0h", out_sum, exp_sum); end
        @(posedge clk);
        #1 model_max = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        start(all_dig(5'd3), 1024'd1000);
        repeat (8) @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b1 || out_sum !== 1028'd1472) begin failures++; $display("FAIL bp_hold%0d got ov=%0h sum=%0h expected 1/%0h", i, out_valid, out_sum, 1028'd1472); end
            checks++; if (in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL bp_flags%0d got ir=%0h busy=%0h expected 0/1", i, in_ready, busy); end
            in_valid  = (i == 2);
            in_digits = all_dig(5'd9);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL bp_idle%0d got ir=%0h ov=%0h busy=%0h expected 1/0/0", i, in_ready, out_valid, busy); end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        start(all_dig(5'd1), '0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL mid_rst_flags got ir=%0h ov=%0h busy=%0h expected 1/0/0", in_ready, out_valid, busy); end
        checks++; if (out_sum !== 1028'd0 || xpb_sel !== 3'd0 || xpb_data !== 5'd0) begin failures++; $display("FAIL mid_rst_data got sum=%0h sel=%0h data=%0h expected 0/0/0", out_sum, xpb_sel, xpb_data); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        start(all_dig(5'd2), 1024'd5);
        repeat (8) @(negedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_sum !== 1028'd469) begin failures++; $display("FAIL post_rst_sum got ov=%0h sum=%0h expected 1/%0h", out_valid, out_sum, 1028'd469); end
        @(posedge clk);
        #1;
    endtask

`ifdef XPB_SKIP_ZERO_EN
    task automatic test_zero_skip();
        logic [39:0] d;
        d = '0;
        d[10 +: 5] = 5'd3;
        d[30 +: 5] = 5'd1;
        start(d, 1024'd100);
        @(negedge clk);
        checks++; if (xpb_sel !== 3'd2 || xpb_data !== 5'd3 || busy !== 1'b1) begin failures++; $display("FAIL skip_first got sel=%0h data=%0h busy=%0h expected 2/3/1", xpb_sel, xpb_data, busy); end
        @(negedge clk);
        checks++; if (xpb_sel !== 3'd6 || xpb_data !== 5'd1 || out_valid !== 1'b0) begin failures++; $display("FAIL skip_second got sel=%0h data=%0h ov=%0h expected 6/1/0", xpb_sel, xpb_data, out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_sum !== 1028'd232) begin failures++; $display("FAIL skip_sum got ov=%0h sum=%0h expected 1/%0h", out_valid, out_sum, 1028'd232); end
        @(posedge clk);
        #1;
    endtask
`endif

    task automatic test_all_zero();
        start('0, 1024'd7);
`ifdef XPB_SKIP_ZERO_EN
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_sum !== 1028'd7) begin failures++; $display("FAIL zero_sum got ov=%0h sum=%0h expected 1/7", out_valid, out_sum); end
`else
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++; if (out_valid !== 1'b0 || xpb_sel !== 3'(k)) begin failures++; $display("FAIL zero_step%0d got ov=%0h sel=%0h expected 0/%0h", k, out_valid, xpb_sel, k); end
        end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_sum !== 1028'd455) begin failures++; $display("FAIL zero_sum got ov=%0h sum=%0h expected 1/%0h", out_valid, out_sum, 1028'd455); end
`endif
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_fixed_latency();
        test_acc_width();
        test_backpressure();
        test_reset_mid();
`ifdef XPB_SKIP_ZERO_EN
        test_zero_skip();
`endif
        test_all_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at time %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/xpb_reduce_sequencer.md
# xpb_reduce_sequencer

Sequencer that drives the XPB reduction lookup tables for one wide operand. It takes the upper digits of a product split into `NUM_SEG` segments of `SEG_BITS` bits and walks through them one per cycle. For each segment it presents the table select and the digit, and adds the returned `XPB_BITS`-bit precomputed value into an accumulator seeded with the operand's lower part. It sits between the squaring multiplier output and the modular reduction adder tree, so that one external table port serves all segments.

## Interface
Parameters:
- `NUM_SEG`, 8: number of digit segments / tables walked.
- `SEG_BITS`, 5: digit width; table input width.
- `XPB_BITS`, 1024: table output width.
- `ACC_BITS`, 1028: accumulator width. Must be ≥ `XPB_BITS + $clog2(NUM_SEG+1)`.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous active-low reset.
- `in_valid`, input, 1: request valid.
- `in_ready`, output, 1: block can accept a request.
- `in_digits`, input, `NUM_SEG*SEG_BITS`: segment k is at `[k*SEG_BITS +: SEG_BITS]`.
- `in_base`, input, `XPB_BITS`: initial accumulator value, zero-extended.
- `xpb_sel`, output, `$clog2(NUM_SEG)`: index of the table being read.
- `xpb_data`, output, `SEG_BITS`: digit presented to the table.
- `xpb_value`, input, `XPB_BITS`: table output, combinational in the same cycle.
- `out_valid`, output, 1: result valid.
- `out_ready`, input, 1: consumer accepts the result.
- `out_sum`, output, `ACC_BITS`: accumulated result.
- `busy`, output, 1: high in LOOKUP or DONE.

## Operation
- FSM states: IDLE, LOOKUP, DONE.
- IDLE:
  - `in_ready`=1.
  - On `in_valid` it registers `in_digits`, sets acc = `in_base`, seg = 0, and goes to LOOKUP.
- LOOKUP, one segment per cycle:
  - Drives `xpb_sel`=seg and `xpb_data`=digit[seg].
  - At the clock edge, acc ← acc + `xpb_value`.
  - seg increments. After segment `NUM_SEG-1` the FSM goes to DONE.
- DONE:
  - `out_valid`=1 and `out_sum`=acc.
  - When `out_valid && out_ready`, the FSM goes to IDLE.
- Outside LOOKUP, `xpb_sel` and `xpb_data` are 0.
- `in_ready` is high only in IDLE. `in_valid` is ignored in LOOKUP and DONE, and the request is not captured.
- Arithmetic is unsigned, modulo 2^`ACC_BITS`. There is no saturation and no overflow flag.
- `out_sum` and the registered digits stay stable from entry to DONE until the output handshake.
- Asserting `rst_n` low at any time forces IDLE, clears acc, seg and the digit register, and discards any in-flight request.
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `busy`=0, `out_sum`=0, `xpb_sel`=0, `xpb_data`=0.

## Timing
- Input handshake at cycle T.
- LOOKUP occupies cycles T+1 to T+`NUM_SEG`.
- `out_valid` rises at T+`NUM_SEG`+1.
- Output handshake at cycle U. The FSM is in IDLE at U+1, and the earliest next input handshake is at U+1.
- Throughput is one request per `NUM_SEG`+2 cycles when `out_ready` is held at 1.
- `xpb_value` is sampled in the same cycle as `xpb_sel`/`xpb_data`, so the table path is combinational. Registered tables are not supported.

## Configuration
- Macro `XPB_SKIP_ZERO_EN`.
- Defined:
  - LOOKUP visits only segments whose digit is nonzero, in ascending index order. The next index comes from a priority encoder over the remaining nonzero digits.
  - Entry from IDLE goes to the first nonzero segment.
  - If all digits are zero, the FSM goes from IDLE straight to DONE, so `out_valid` rises at T+1 with `out_sum`=`in_base`.
  - Latency is (number of nonzero digits)+1.
- Undefined: fixed `NUM_SEG` LOOKUP cycles, including zero digits.

## Test plan
Default parameters throughout. The bench table model returns `xpb_value` = `xpb_sel`*16 + `xpb_data`.

- **Fixed latency:** `in_base`=0, all digits=1, macro off → `out_valid` at T+9; `out_sum`=456; `xpb_sel` steps 0..7 on T+1..T+8.
- **Accumulator width:** model returns 2^1024−1 for every lookup, `in_base`=2^1024−1 → `out_sum`=9·(2^1024−1), no wrap in 1028 bits.
- **Output backpressure:** `out_ready` low for 5 cycles after `out_valid` → `out_valid` and `out_sum` held; `in_ready`=0; a new `in_valid` pulse is not captured.
- **Reset mid-operation:** `rst_n` pulsed low at T+3 → all outputs return to reset values immediately. A following request with digits all 2 and `in_base`=5 yields `out_sum`=5+Σ(k·16+2)=469.
- **Zero skipping, macro on:** digits nonzero only at seg 2 (=3) and seg 6 (=1) → LOOKUP at T+1 and T+2 with `xpb_sel`=2 then 6; `out_valid` at T+3; `out_sum`=`in_base`+35+97.
- **All-zero digits, macro on:** all digits 0, `in_base`=7 → `out_valid` at T+1 with `out_sum`=7. With the macro off, `out_valid` is at T+9 with `out_sum`=7+448=455.
